// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage data port between pipeline (master) and memory responder (slave)
//   MEM   : request opcode, 01 load, 10 store, 00/11 idle (master -> slave)
//   Addr  : byte address, word-aligned (master -> slave)
//   Wdata : store data (master -> slave)
//   Rdata : registered load result (slave -> master)
//   BUSY  : stall request to pipeline control (slave -> master)
//   ERR   : illegal-access flag, valid in the response cycle (slave -> master)
interface dmem_responder_if;
   logic [1:0]  MEM;
   logic [31:0] Addr;
   logic [31:0] Wdata;
   logic [31:0] Rdata;
   logic        BUSY;
   logic        ERR;
   modport master (output MEM, Addr, Wdata, input Rdata, BUSY, ERR);
   modport slave (input MEM, Addr, Wdata, output Rdata, BUSY, ERR);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory answering each MEM-stage request after LATENCY wait cycles
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   dmem : slave side of dmem_responder_if (MEM/Addr/Wdata in, Rdata/BUSY/ERR out)
//   AW      : word-address width, memory holds 2**AW words
//   LATENCY : wait cycles before an access completes, 1..15
module dmem_responder #(
   parameter int AW      = 10,
   parameter int LATENCY = 2
) (
   input logic               clk,
   input logic               rst,
   dmem_responder_if.slave   dmem
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        busy;
   logic [31:0] mem [2**AW];
   logic        req;
   logic        legal;
   logic        access;
   logic [AW-1:0] idx;
   assign req    = dmem.MEM == 2'b01 || dmem.MEM == 2'b10;
   assign legal  = addr_q[1:0] == 2'b00 && addr_q[31:AW+2] == '0;
   assign idx    = addr_q[AW+1:2];
   // the access happens on the edge that leaves WAIT; rst on that edge cancels it
   assign access = state_q == WAIT && cnt_q == 4'd0 && !rst;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;
      busy    = 1'b0;
      case (state_q)
         IDLE: if (req) begin
            busy    = 1'b1;
            op_d    = dmem.MEM;
            addr_d  = dmem.Addr;
            wdata_d = dmem.Wdata;
            cnt_d   = 4'(LATENCY - 1);
            state_d = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            else begin
               state_d = RESP;
               err_d   = !legal;
               if (op_q == 2'b01) rdata_d = legal ? mem[idx] : 32'h0;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         op_q    <= 2'b00;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end
   always_ff @(posedge clk) begin
      if (access && legal && op_q == 2'b10) mem[idx] <= wdata_q;
   end
   assign dmem.BUSY  = busy && !rst;
   assign dmem.Rdata = rdata_q;
   assign dmem.ERR   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench for dmem_responder (LATENCY=2 main instance, LATENCY=1 side instance)
module tb_dmem_responder;
   localparam int LAT = 2;
   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   dmem_responder_if bus ();
   dmem_responder_if bus1 ();
   dmem_responder #(.AW(10), .LATENCY(LAT)) u_dut (.clk(clk), .rst(rst), .dmem(bus));
   dmem_responder #(.AW(10), .LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .dmem(bus1));
   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];
   logic [31:0] mem_m [int];
   logic [31:0] cur_rd = 32'h0;
   bit mon_en = 1'b0;
   logic [31:0] pool [10];
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask
   // monitor: a high-to-low BUSY transition marks the response cycle
   int run = 0;
   logic [31:0] last_rd = 32'h0;
   always @(negedge clk) begin
      if (!mon_en) begin
         run = 0;
         last_rd = 32'h0;
      end else if (bus.BUSY) begin
         chk("rdata_hold", bus.Rdata, last_rd);
         chk("err_quiet", {31'h0, bus.ERR}, 32'h0);
         run++;
      end else if (run > 0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got response with empty scoreboard at %0t", $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp_rdata", bus.Rdata, e.rdata);
            chk("resp_err", {31'h0, bus.ERR}, {31'h0, e.err});
            chk("busy_len", run, LAT + 1);
            last_rd = e.rdata;
         end
         run = 0;
      end else begin
         chk("rdata_hold", bus.Rdata, last_rd);
         chk("err_quiet", {31'h0, bus.ERR}, 32'h0);
      end
   end
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d, input bit scribble);
      bit legal;
      exp_t e;
      int n;
      @(posedge clk);
      #1;
      bus.MEM = op;
      bus.Addr = a;
      bus.Wdata = d;
      if (op != 2'b01 && op != 2'b10) return;
      legal = a[1:0] == 2'b00 && a[31:12] == 20'h0;
      if (op == 2'b01) cur_rd = legal ? mem_m[int'(a[11:2])] : 32'h0;
      else if (legal) mem_m[int'(a[11:2])] = d;
      e.rdata = cur_rd;
      e.err = !legal;
      exp_q.push_back(e);
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         if (!bus.BUSY) break;
         if (n > 40) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got BUSY stuck high, required release within 40 cycles");
            break;
         end
         // WAIT must ignore changed inputs
         if (scribble && n >= 2) begin
            #1;
            bus.MEM = 2'b10;
            bus.Addr = $urandom & 32'h0000_0FFC;
            bus.Wdata = $urandom;
         end
      end
   endtask
   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         bus.MEM = $urandom_range(0, 1) ? 2'b00 : 2'b11;
         bus.Addr = $urandom;
      end
   endtask
   task automatic issue1(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d, input logic [31:0] want_rd);
      logic [2:0] pat;
      @(posedge clk);
      #1;
      bus1.MEM = op;
      bus1.Addr = a;
      bus1.Wdata = d;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pat[2-i] = bus1.BUSY;
      end
      chk("lat1_busy_pattern", {29'h0, pat}, 32'h6);
      chk("lat1_rdata", bus1.Rdata, want_rd);
      chk("lat1_err", {31'h0, bus1.ERR}, 32'h0);
   endtask
   initial begin
      bus.MEM = 2'b01;
      bus.Addr = 32'h10;
      bus.Wdata = 32'h0;
      bus1.MEM = 2'b00;
      bus1.Addr = 32'h0;
      bus1.Wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("busy_in_reset", {31'h0, bus.BUSY}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.MEM = 2'b00;
      @(negedge clk);
      chk("reset_busy", {31'h0, bus.BUSY}, 32'h0);
      chk("reset_rdata", bus.Rdata, 32'h0);
      chk("reset_err", {31'h0, bus.ERR}, 32'h0);
      mon_en = 1'b1;
      issue(2'b10, 32'h10, 32'hDEADBEEF, 1'b0);
      issue(2'b01, 32'h10, 32'h0, 1'b0);
      idle(5);
      issue(2'b01, 32'h13, 32'h0, 1'b0);
      issue(2'b01, 32'h0000_1000, 32'h0, 1'b0);
      issue(2'b01, 32'h10, 32'h0, 1'b0);
      issue(2'b01, 32'h10, 32'h0, 1'b0);
      issue(2'b01, 32'h10, 32'h0, 1'b1);
      issue(2'b01, 32'h10, 32'h0, 1'b0);
      issue(2'b10, 32'h20, 32'h0BADF00D, 1'b0);
      // reset on the edge that would perform a store to 0x20
      @(posedge clk);
      #1;
      mon_en = 1'b0;
      bus.MEM = 2'b10;
      bus.Addr = 32'h20;
      bus.Wdata = 32'h12345678;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.MEM = 2'b00;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cur_rd = 32'h0;
      @(negedge clk);
      chk("midrst_busy", {31'h0, bus.BUSY}, 32'h0);
      chk("midrst_rdata", bus.Rdata, 32'h0);
      mon_en = 1'b1;
      issue(2'b01, 32'h20, 32'h0, 1'b0);
      for (int i = 0; i < 9; i++) pool[i] = 32'(i * 4);
      pool[9] = 32'hFFC;
      for (int i = 0; i < 10; i++) issue(2'b10, pool[i], $urandom, 1'b0);
      for (int t = 0; t < 150; t++) begin
         int r;
         logic [31:0] a;
         a = pool[$urandom_range(0, 9)];
         r = $urandom_range(0, 9);
         if (r == 0) a = a | 32'($urandom_range(1, 3));
         else if (r == 1) a = a | (32'h1 << $urandom_range(12, 31));
         r = $urandom_range(0, 9);
         if (r < 4) issue(2'b01, a, $urandom, $urandom_range(0, 3) == 0);
         else if (r < 8) issue(2'b10, a, $urandom, $urandom_range(0, 3) == 0);
         else idle($urandom_range(1, 3));
      end
      idle(3);
      @(negedge clk);
      chk("queue_empty", exp_q.size(), 32'h0);
      @(posedge clk);
      #1;
      bus1.MEM = 2'b11;
      bus1.Addr = 32'h10;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("op11_busy", {31'h0, bus1.BUSY}, 32'h0);
         chk("op11_err", {31'h0, bus1.ERR}, 32'h0);
      end
      issue1(2'b10, 32'h10, 32'hCAFE0001, 32'h0);
      issue1(2'b01, 32'h10, 32'h0, 32'hCAFE0001);
      issue1(2'b10, 32'h14, 32'h55AA55AA, 32'hCAFE0001);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
